// File: rtl/mac_multiplex_pkg.sv
// Shared state type, lane constants and precision helpers for the MAC operand
// packer and its lane gatherer.
package mac_multiplex_pkg;

  localparam int CFG_AW_W   = 2;
  localparam int MAX_LANES  = 2 ** CFG_AW_W;
  localparam int LANE_CNT_W = $clog2(MAX_LANES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN
  } packer_state_t;

  // Code 2 has no lane layout of its own and runs as code 1.
  function automatic logic [CFG_AW_W-1:0] coerce_prec(input logic [CFG_AW_W-1:0] prec);
    return (prec == CFG_AW_W'(2)) ? CFG_AW_W'(1) : prec;
  endfunction

  function automatic logic [LANE_CNT_W-1:0] lanes_from_cfg(input logic [CFG_AW_W-1:0] prec);
    logic [LANE_CNT_W-1:0] lanes;
    case (coerce_prec(prec))
      CFG_AW_W'(0): lanes = LANE_CNT_W'(1);
      CFG_AW_W'(1): lanes = LANE_CNT_W'(2);
      default:      lanes = LANE_CNT_W'(MAX_LANES);
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mac_lane_gather.sv
// Collects 1, 2 or 4 shifted/truncated operand pairs into one packed word and
// flags the beat that fills the last lane.
module mac_lane_gather
  import mac_multiplex_pkg::*;
#(
  parameter int W_WIDTH = 8,
  parameter int A_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_accept,
  input  logic [LANE_CNT_W-1:0]      i_lanes,
  input  logic [$clog2(W_WIDTH)-1:0] i_w_shift,
  input  logic [$clog2(A_WIDTH)-1:0] i_a_shift,
  input  logic [W_WIDTH-1:0]         i_w,
  input  logic [A_WIDTH-1:0]         i_a,
  output logic                       o_word_complete,
  output logic [W_WIDTH-1:0]         o_word_w,
  output logic [A_WIDTH-1:0]         o_word_a
);

  localparam int IDX_W = $clog2(MAX_LANES);

  logic [IDX_W-1:0]   r_lane_idx;
  logic [W_WIDTH-1:0] r_gather_w;
  logic [A_WIDTH-1:0] r_gather_a;

  int unsigned        w_lane_width;
  int unsigned        w_w_sh;
  int unsigned        w_a_sh;
  int unsigned        w_pos;
  logic [W_WIDTH-1:0] w_w_mask;
  logic [W_WIDTH-1:0] w_w_lane;
  logic [A_WIDTH-1:0] w_a_mask;
  logic [A_WIDTH-1:0] w_a_lane;
  logic               w_last_lane;

  always_comb begin
    case (i_lanes)
      LANE_CNT_W'(1): w_lane_width = W_WIDTH;
      LANE_CNT_W'(2): w_lane_width = W_WIDTH / 2;
      default:        w_lane_width = W_WIDTH / MAX_LANES;
    endcase
    // Lane widths are powers of two, so masking reduces the shift modulo the lane width.
    w_w_sh   = 32'(i_w_shift) & (w_lane_width - 1);
    w_a_sh   = 32'(i_a_shift) & (w_lane_width - 1);
    w_pos    = 32'(r_lane_idx) * w_lane_width;
    w_w_mask = {W_WIDTH{1'b1}} >> (W_WIDTH - w_lane_width);
    w_a_mask = {A_WIDTH{1'b1}} >> (A_WIDTH - w_lane_width);
    w_w_lane = ((i_w << w_w_sh) & w_w_mask) << w_pos;
    w_a_lane = ((i_a << w_a_sh) & w_a_mask) << w_pos;

    w_last_lane     = (32'(r_lane_idx) + 32'd1) == 32'(i_lanes);
    o_word_complete = i_accept && w_last_lane;
    // Lane 0 starts from zero so bits of the previous word never leak in.
    o_word_w = ((r_lane_idx == '0) ? '0 : r_gather_w) | w_w_lane;
    o_word_a = ((r_lane_idx == '0) ? '0 : r_gather_a) | w_a_lane;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane_idx <= '0;
      r_gather_w <= '0;
      r_gather_a <= '0;
    end else if (i_accept) begin
      r_lane_idx <= w_last_lane ? '0 : r_lane_idx + 1'b1;
      r_gather_w <= o_word_w;
      r_gather_a <= o_word_a;
    end
  end

endmodule

// File: rtl/mac_operand_packer.sv
// Streaming front-end for the multiplexed MAC: packs operand pairs into lane
// words and sequences fixed-length accumulation runs with zero bubbles.
module mac_operand_packer
  import mac_multiplex_pkg::*;
#(
  parameter int W_WIDTH         = 8,
  parameter int A_WIDTH         = 8,
  parameter int CONFIG_AW_WIDTH = CFG_AW_W,
  parameter int ACCU_LEN        = 50
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [CONFIG_AW_WIDTH-1:0] cfg_prec,
  input  logic [$clog2(W_WIDTH)-1:0] cfg_w_shift,
  input  logic [$clog2(A_WIDTH)-1:0] cfg_a_shift,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W_WIDTH-1:0]         in_w,
  input  logic [A_WIDTH-1:0]         in_a,
  output logic [W_WIDTH-1:0]         mac_w,
  output logic [A_WIDTH-1:0]         mac_a,
  output logic [CONFIG_AW_WIDTH-1:0] mac_config_aw,
  output logic                       mac_accu_rst,
  output logic                       busy,
  output logic                       run_done
);

  localparam int               CNT_W     = (ACCU_LEN > 1) ? $clog2(ACCU_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(ACCU_LEN - 1);
  localparam int               WS_W      = $clog2(W_WIDTH);
  localparam int               AS_W      = $clog2(A_WIDTH);

  packer_state_t              r_state, w_state_next;
  logic [CNT_W-1:0]           r_word_cnt, w_word_cnt_next;
  logic                       r_stop, w_stop_next;
  logic [CONFIG_AW_WIDTH-1:0] r_config_aw, w_config_aw_next;
  logic [WS_W-1:0]            r_w_shift, w_w_shift_next;
  logic [AS_W-1:0]            r_a_shift, w_a_shift_next;
  logic [W_WIDTH-1:0]         r_mac_w, w_mac_w_next;
  logic [A_WIDTH-1:0]         r_mac_a, w_mac_a_next;
  logic                       r_accu_rst, w_accu_rst_next;
  logic                       r_in_ready, w_in_ready_next;
  logic                       r_busy, w_busy_next;
  logic                       r_run_done, w_run_done_next;

  logic                       w_accept;
  logic                       w_word_complete;
  logic [W_WIDTH-1:0]         w_word_w;
  logic [A_WIDTH-1:0]         w_word_a;
  logic [LANE_CNT_W-1:0]      w_lanes;

  assign w_accept = in_valid && r_in_ready;
  assign w_lanes  = lanes_from_cfg(r_config_aw);

  mac_lane_gather #(
    .W_WIDTH (W_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_gather (
    .clk             (clk),
    .rst             (rst),
    .i_accept        (w_accept),
    .i_lanes         (w_lanes),
    .i_w_shift       (r_w_shift),
    .i_a_shift       (r_a_shift),
    .i_w             (in_w),
    .i_a             (in_a),
    .o_word_complete (w_word_complete),
    .o_word_w        (w_word_w),
    .o_word_a        (w_word_a)
  );

  always_comb begin
    w_state_next     = r_state;
    w_word_cnt_next  = r_word_cnt;
    w_stop_next      = r_stop || stop;
    w_config_aw_next = r_config_aw;
    w_w_shift_next   = r_w_shift;
    w_a_shift_next   = r_a_shift;
    w_mac_w_next     = '0;
    w_mac_a_next     = '0;

    case (r_state)
      IDLE: begin
        w_stop_next = 1'b0;
        if (start) begin
          w_state_next     = CLEAR;
          w_config_aw_next = coerce_prec(cfg_prec);
          w_w_shift_next   = cfg_w_shift;
          w_a_shift_next   = cfg_a_shift;
        end
      end
      CLEAR: w_state_next = ISSUE;
      ISSUE: begin
        if (w_word_complete) begin
          w_mac_w_next = w_word_w;
          w_mac_a_next = w_word_a;
          if (r_word_cnt == LAST_WORD) begin
            w_word_cnt_next = '0;
            w_state_next    = DRAIN;
          end else begin
            w_word_cnt_next = r_word_cnt + 1'b1;
          end
        end
      end
      DRAIN:   w_state_next = w_stop_next ? IDLE : CLEAR;
      default: w_state_next = IDLE;
    endcase

    if (w_state_next == IDLE) w_stop_next = 1'b0;

    // Flags are decoded from the next state so every output comes straight from a flop.
    w_accu_rst_next = (w_state_next == IDLE) || (w_state_next == CLEAR);
    w_in_ready_next = (w_state_next == ISSUE);
    w_busy_next     = (w_state_next != IDLE);
    w_run_done_next = (w_state_next == DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_word_cnt  <= '0;
      r_stop      <= 1'b0;
      r_config_aw <= '1;
      r_w_shift   <= '0;
      r_a_shift   <= '0;
      r_mac_w     <= '0;
      r_mac_a     <= '0;
      r_accu_rst  <= 1'b1;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_run_done  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_word_cnt  <= w_word_cnt_next;
      r_stop      <= w_stop_next;
      r_config_aw <= w_config_aw_next;
      r_w_shift   <= w_w_shift_next;
      r_a_shift   <= w_a_shift_next;
      r_mac_w     <= w_mac_w_next;
      r_mac_a     <= w_mac_a_next;
      r_accu_rst  <= w_accu_rst_next;
      r_in_ready  <= w_in_ready_next;
      r_busy      <= w_busy_next;
      r_run_done  <= w_run_done_next;
    end
  end

  assign mac_w         = r_mac_w;
  assign mac_a         = r_mac_a;
  assign mac_config_aw = r_config_aw;
  assign mac_accu_rst  = r_accu_rst;
  assign in_ready      = r_in_ready;
  assign busy          = r_busy;
  assign run_done      = r_run_done;

endmodule

// File: tb/tb_mac_operand_packer.sv
// Scenario bench for mac_operand_packer: expected {mac_w, mac_a} words are queued
// as beats are driven and popped in the cycle the packer should present them.
module tb_mac_operand_packer;

  localparam int ACCU = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] cfg_prec;
  logic [2:0] cfg_w_shift;
  logic [2:0] cfg_a_shift;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_w;
  logic [7:0] in_a;
  logic [7:0] mac_w;
  logic [7:0] mac_a;
  logic [1:0] mac_config_aw;
  logic       mac_accu_rst;
  logic       busy;
  logic       run_done;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_word;

  always #5 clk = ~clk;

  mac_operand_packer #(
    .W_WIDTH         (8),
    .A_WIDTH         (8),
    .CONFIG_AW_WIDTH (2),
    .ACCU_LEN        (ACCU)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .cfg_prec      (cfg_prec),
    .cfg_w_shift   (cfg_w_shift),
    .cfg_a_shift   (cfg_a_shift),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_w          (in_w),
    .in_a          (in_a),
    .mac_w         (mac_w),
    .mac_a         (mac_a),
    .mac_config_aw (mac_config_aw),
    .mac_accu_rst  (mac_accu_rst),
    .busy          (busy),
    .run_done      (run_done)
  );

  // Reference lane value: operand shifted by (shift mod lane width), kept to lane width bits.
  function automatic logic [7:0] lane_val(input logic [7:0] v, input int sh, input int lanes);
    int lw;
    int t;
    lw = 8 / lanes;
    t  = int'(v) << (sh % lw);
    return 8'(t % (1 << lw));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_w = '0; in_a = '0;
    exp_q.delete();
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic start_run(input logic [1:0] p, input logic [2:0] ws, input logic [2:0] as);
    cfg_prec = p; cfg_w_shift = ws; cfg_a_shift = as; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks++; if (mac_accu_rst !== 1'b1) begin failures++; $display("FAIL reset_accu_rst: got %b expected 1", mac_accu_rst); end
    checks++; if (mac_config_aw !== 2'b11) begin failures++; $display("FAIL reset_config_aw: got %b expected 11", mac_config_aw); end
    checks++; if ({in_ready, busy, run_done} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {in_ready, busy, run_done}); end
    checks++; if ({mac_w, mac_a} !== 16'h0000) begin failures++; $display("FAIL reset_words: got %h expected 0000", {mac_w, mac_a}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_pack4();
    logic [7:0]  ws [12];
    logic [15:0] words [3];
    ws    = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    words = '{16'h3955, 16'h5555, 16'hFF55};
    do_reset();
    cfg_prec = 2'd3; cfg_w_shift = 3'd0; cfg_a_shift = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({busy, mac_accu_rst, in_ready} !== 3'b110) begin failures++; $display("FAIL p4_clear: got %b expected 110", {busy, mac_accu_rst, in_ready}); end
    tick();
    checks++; if ({in_ready, mac_accu_rst} !== 2'b10) begin failures++; $display("FAIL p4_issue: got %b expected 10", {in_ready, mac_accu_rst}); end
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_w = ws[i]; in_a = 8'h01;
      if (i % 4 == 3) exp_q.push_back(words[i / 4]);
      tick();
      if (i % 4 == 3) begin
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++; if ({mac_w, mac_a} !== exp_word) begin failures++; $display("FAIL p4_word%0d: got %h expected %h", i / 4, {mac_w, mac_a}, exp_word); end
      end else begin
        checks++; if ({mac_w, mac_a, mac_accu_rst} !== 17'h0) begin failures++; $display("FAIL p4_bubble%0d: got %h expected 00000", i, {mac_w, mac_a, mac_accu_rst}); end
      end
    end
    in_valid = 1'b0;
    checks++; if ({run_done, in_ready, busy} !== 3'b101) begin failures++; $display("FAIL p4_drain: got %b expected 101", {run_done, in_ready, busy}); end
    tick();
    checks++; if ({run_done, mac_accu_rst, busy, mac_w} !== {3'b011, 8'h00}) begin failures++; $display("FAIL p4_clear_after: got %h expected %h", {run_done, mac_accu_rst, busy, mac_w}, {3'b011, 8'h00}); end
  endtask

  task automatic test_shift();
    do_reset();
    start_run(2'd1, 3'd1, 3'd0);
    in_valid = 1'b1; in_w = 8'h05; in_a = 8'h03;
    tick();
    checks++; if ({mac_w, mac_a} !== 16'h0000) begin failures++; $display("FAIL shift_half: got %h expected 0000", {mac_w, mac_a}); end
    exp_q.push_back(16'hAA33);
    tick();
    in_valid = 1'b0;
    exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++; if ({mac_w, mac_a} !== exp_word) begin failures++; $display("FAIL shift_word: got %h expected %h", {mac_w, mac_a}, exp_word); end
    checks++; if (mac_config_aw !== 2'd1) begin failures++; $display("FAIL shift_config_aw: got %0d expected 1", mac_config_aw); end
  endtask

  task automatic test_coerce();
    logic [7:0] lw;
    logic [7:0] la;
    do_reset();
    start_run(2'd2, 3'd5, 3'd4);
    checks++; if (mac_config_aw !== 2'd1) begin failures++; $display("FAIL coerce_config_aw: got %0d expected 1", mac_config_aw); end
    lw = lane_val(8'h05, 5, 2);
    la = lane_val(8'h03, 4, 2);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_w = 8'h05; in_a = 8'h03;
      if (i == 1) exp_q.push_back({lw | (lw << 4), la | (la << 4)});
      tick();
    end
    in_valid = 1'b0;
    exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++; if ({mac_w, mac_a} !== exp_word) begin failures++; $display("FAIL coerce_word: got %h expected %h", {mac_w, mac_a}, exp_word); end
  endtask

  task automatic test_bubble();
    logic       vs [4];
    logic [7:0] ws [4];
    logic [7:0] as [4];
    vs = '{1'b1, 1'b0, 1'b1, 1'b1};
    ws = '{8'h11, 8'hEE, 8'h33, 8'h55};
    as = '{8'h22, 8'hDD, 8'h44, 8'h66};
    do_reset();
    start_run(2'd0, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = vs[i]; in_w = ws[i]; in_a = as[i];
      if (vs[i]) exp_q.push_back({ws[i], as[i]});
      tick();
      if (vs[i]) begin
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++; if ({mac_w, mac_a} !== exp_word) begin failures++; $display("FAIL bubble_word%0d: got %h expected %h", i, {mac_w, mac_a}, exp_word); end
      end else begin
        checks++; if ({mac_w, mac_a, mac_accu_rst, in_ready} !== {16'h0, 2'b01}) begin failures++; $display("FAIL bubble_gap: got %h expected %h", {mac_w, mac_a, mac_accu_rst, in_ready}, {16'h0, 2'b01}); end
      end
      if (i >= 2) begin
        checks++; if (run_done !== (i == 3)) begin failures++; $display("FAIL bubble_run_done%0d: got %b expected %b", i, run_done, (i == 3)); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stop();
    logic [7:0] w;
    logic [7:0] a;
    do_reset();
    start_run(2'd0, 3'd0, 3'd0);
    for (int i = 0; i < ACCU; i++) begin
      w = 8'($urandom); a = 8'($urandom);
      in_valid = 1'b1; in_w = w; in_a = a;
      stop  = (i == 0);
      start = (i == 1);
      if (i == 1) cfg_prec = 2'd3;
      exp_q.push_back({w, a});
      tick();
      exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      checks++; if ({mac_w, mac_a} !== exp_word) begin failures++; $display("FAIL stop_word%0d: got %h expected %h", i, {mac_w, mac_a}, exp_word); end
    end
    stop = 1'b0; start = 1'b0; in_valid = 1'b0;
    checks++; if (run_done !== 1'b1) begin failures++; $display("FAIL stop_drain: got %b expected 1", run_done); end
    tick();
    checks++; if ({busy, mac_accu_rst, in_ready, run_done} !== 4'b0100) begin failures++; $display("FAIL stop_idle: got %b expected 0100", {busy, mac_accu_rst, in_ready, run_done}); end
    checks++; if (mac_config_aw !== 2'd0) begin failures++; $display("FAIL stop_config_aw: got %0d expected 0", mac_config_aw); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_stays_idle: got %b expected 0", busy); end
  endtask

  task automatic test_stop_in_drain();
    do_reset();
    start_run(2'd0, 3'd0, 3'd0);
    for (int i = 0; i < ACCU; i++) begin
      in_valid = 1'b1; in_w = 8'(i + 1); in_a = 8'(i + 9);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (run_done !== 1'b1) begin failures++; $display("FAIL drain_stop_pre: got %b expected 1", run_done); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if ({busy, mac_accu_rst} !== 2'b01) begin failures++; $display("FAIL drain_stop_idle: got %b expected 01", {busy, mac_accu_rst}); end
  endtask

  task automatic test_back_to_back();
    logic       rdy;
    logic [7:0] w;
    logic [7:0] a;
    int         n_done = 0;
    int         first_done = -1;
    int         last_done = -1;
    do_reset();
    start_run(2'd0, 3'd3, 3'd0);
    for (int i = 0; i < 12; i++) begin
      rdy = in_ready;
      w = 8'($urandom); a = 8'($urandom);
      in_valid = 1'b1; in_w = w; in_a = a;
      if (rdy) exp_q.push_back({lane_val(w, 3, 1), a});
      tick();
      if (rdy) begin
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++; if ({mac_w, mac_a} !== exp_word) begin failures++; $display("FAIL b2b_word%0d: got %h expected %h", i, {mac_w, mac_a}, exp_word); end
      end else begin
        checks++; if ({mac_w, mac_a} !== 16'h0) begin failures++; $display("FAIL b2b_gap%0d: got %h expected 0000", i, {mac_w, mac_a}); end
      end
      if (run_done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = i;
        last_done = i;
      end
    end
    in_valid = 1'b0;
    checks++; if (n_done !== 2) begin failures++; $display("FAIL b2b_runs: got %0d expected 2", n_done); end
    checks++; if (last_done - first_done !== ACCU + 2) begin failures++; $display("FAIL b2b_period: got %0d expected %0d", last_done - first_done, ACCU + 2); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    start_run(2'd3, 3'd0, 3'd0);
    in_valid = 1'b1; in_w = 8'h03; in_a = 8'h03;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if ({in_ready, busy, mac_accu_rst} !== 3'b001) begin failures++; $display("FAIL midrst_flags: got %b expected 001", {in_ready, busy, mac_accu_rst}); end
    checks++; if (mac_config_aw !== 2'b11) begin failures++; $display("FAIL midrst_config_aw: got %b expected 11", mac_config_aw); end
    tick();
    rst = 1'b1;
    tick();
    start_run(2'd3, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_w = 8'h01; in_a = 8'h02;
      if (i == 3) exp_q.push_back(16'h55AA);
      tick();
      if (i == 3) begin
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++; if ({mac_w, mac_a} !== exp_word) begin failures++; $display("FAIL midrst_word: got %h expected %h", {mac_w, mac_a}, exp_word); end
      end else begin
        checks++; if ({mac_w, mac_a} !== 16'h0) begin failures++; $display("FAIL midrst_early%0d: got %h expected 0000", i, {mac_w, mac_a}); end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_prec = '0; cfg_w_shift = '0; cfg_a_shift = '0;
    in_valid = 1'b0; in_w = '0; in_a = '0;
    test_reset();
    test_pack4();
    test_shift();
    test_coerce();
    test_bubble();
    test_stop();
    test_stop_in_drain();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mac_operand_packer.md
# mac_operand_packer

Streaming front-end for `top_mac_multiplex`. Accepts one (w, a) operand pair per handshake beat and left-aligns each operand to the active lane width. Packs 1, 2 or 4 pairs into one W_WIDTH/A_WIDTH word and drives the MAC's `w`, `a`, `config_aw` and `accu_rst` in fixed-length accumulation runs. Cycles without a complete word issue zero operands, so the MAC accumulator is never corrupted.

## Interface

Parameters:
- `W_WIDTH`, 8: weight word width; equals the MAC's.
- `A_WIDTH`, 8: activation word width; must equal `W_WIDTH`.
- `CONFIG_AW_WIDTH`, 2: width of the MAC precision config.
- `ACCU_LEN`, 50: packed words per accumulation run, ≥1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous and active-low.
- `start`  in  1  pulse; begins runs, honoured only in IDLE.
- `stop`  in  1  pulse; latched, ends after the current run.
- `cfg_prec`  in  CONFIG_AW_WIDTH  lanes minus 1; sampled on `start`.
- `cfg_w_shift`  in  $clog2(W_WIDTH)  lane width minus chosen w width; sampled on `start`.
- `cfg_a_shift`  in  $clog2(A_WIDTH)  lane width minus chosen a width; sampled on `start`.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  packer accepts the pair.
- `in_w`  in  W_WIDTH  signed weight, LSB-justified at the chosen width.
- `in_a`  in  A_WIDTH  unsigned activation, LSB-justified.
- `mac_w`  out  W_WIDTH  packed weight word.
- `mac_a`  out  A_WIDTH  packed activation word.
- `mac_config_aw`  out  CONFIG_AW_WIDTH  MAC precision config.
- `mac_accu_rst`  out  1  MAC accumulator clear.
- `busy`  out  1  high when not IDLE.
- `run_done`  out  1  one-cycle pulse per completed run.

## Operation

- Lane count L = 1, 2, 2, 4 for `cfg_prec` = 0, 1, 2, 3. A value of 2 is coerced to 1. Lane width LW = W_WIDTH/L.
- Lane value = (operand << shift) truncated to LW bits. The shift amount is taken modulo LW.
- The first accepted beat of a word goes into lane 0 (LSBs), the next into lane 1, and so on.
- A beat is accepted when `in_valid && in_ready`. A word completes when lane L-1 is accepted.
- Word counter: counts completed words in the current run, range 0..ACCU_LEN-1.
- IDLE:
  - Outputs: zeros, `mac_accu_rst`=1, `in_ready`=0.
  - On `start`: latch cfg, set `mac_config_aw` = the coerced `cfg_prec`, go to CLEAR.
- CLEAR (1 cycle): zeros, `mac_accu_rst`=1, `in_ready`=0, then go to ISSUE.
- ISSUE:
  - `in_ready`=1, `mac_accu_rst`=0.
  - A completed word appears on `mac_w`/`mac_a` for exactly the next cycle. Every other cycle shows zeros (bubble).
  - When the ACCU_LEN-th word completes, go to DRAIN.
- DRAIN (1 cycle): the last word is on the outputs, `in_ready`=0, `run_done`=1. Go to IDLE if the stop latch is set, else to CLEAR.
- The stop latch is set by `stop` in any non-IDLE state and cleared on entering IDLE. `stop` in IDLE is ignored. `start` outside IDLE is ignored.
- `stop` arriving in the same cycle as DRAIN is honoured: the next state is IDLE.
- `mac_config_aw` is constant between `start` and the return to IDLE.

## Timing

- All outputs are registered. `in_ready` is a function of state only.
- Reset values: `mac_w`=0, `mac_a`=0, `mac_accu_rst`=1, `mac_config_aw`=all ones, `in_ready`=0, `busy`=0, `run_done`=0. The lane index, word counter and stop latch are 0.
- Latency: a word is on the MAC inputs in the cycle after its last beat is accepted.
- Throughput: L beats per word. With L=1 and continuous `in_valid`, there are ACCU_LEN+2 cycles per run (ACCU_LEN ISSUE cycles, DRAIN, CLEAR).
- `start` to the first `in_ready`: 2 cycles (CLEAR, then ISSUE).
- A partially gathered word never spans runs: `in_ready` is 0 outside ISSUE, and ISSUE exits only at a word boundary.
- Reset asserted mid-run: the partial word is discarded and all state and outputs return to reset values immediately.

## Structure

- Package `mac_multiplex_pkg`:
  - state enum `packer_state_t` (IDLE, CLEAR, ISSUE, DRAIN)
  - function `lanes_from_cfg`
  - constant `MAX_LANES` = 2**CONFIG_AW_WIDTH
- Sub-module `mac_lane_gather`: lane index counter, shift/truncate logic and gather register. It produces a `word_complete` strobe and the packed word. The parent holds the FSM, word counter and output registers.

## Test plan

- Reset: hold `rst`=0 → `mac_accu_rst`=1, `mac_config_aw`=2'b11, `in_ready`=0, all other outputs 0.
- `cfg_prec`=3, shifts 0, `ACCU_LEN`=2, 8 beats with w=1,2,3,0,1,1,1,1 and a=1 → words `mac_w`=8'h39 then 8'h55, `run_done` in the DRAIN cycle, then CLEAR with `mac_accu_rst`=1.
- `cfg_prec`=1, `cfg_w_shift`=1, `in_w`=3'b101 (LSB-justified), `in_a`=4'h3 twice → `mac_w`=8'hAA, `mac_a`=8'h33.
- `cfg_prec`=0, `in_valid` toggling 1,0,1 → words separated by one zero bubble with `mac_accu_rst`=0. The word count is unaffected by the bubble.
- `stop` pulsed mid-run with `ACCU_LEN`=3 → the run completes 3 words, then DRAIN, then IDLE with `busy`=0. `start` pulsed while busy → no effect.
- `rst` asserted after 1 of 4 lanes is gathered, released, then restarted → the first word contains only post-restart beats.
